count_arbiter: RTL and testbench

Round-robin scheduler that shares one internal up-counter between `NREQ` requesters. Each requester asks for a counting run of a given length. The block grants the counter to one requester at a time, counts from 0 up to that requester's length, and reports completion or abort. It sits in front of the counting datapath as its sole sequencer: requesters never drive the counter directly.

---
 rtl/count_arbiter_pkg.sv | 18 +
 rtl/count_arbiter_rr_pick.sv | 29 ++
 rtl/count_arbiter.sv | 115 +++++++++++
 tb/tb_count_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/count_arbiter_pkg.sv
// Shared types and helpers for the round-robin counter arbiter.
package count_arbiter_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  // Callers narrow the result to their requester count (up to 32).
  function automatic logic [31:0] onehot(input int idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/count_arbiter_rr_pick.sv
// Combinational round-robin search: first set request above the last owner, wrapping.
module rr_pick
  import count_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [IW-1:0]   o_winner,
  output logic            o_any
);

  always_comb begin
    logic [IW-1:0] w_cand;
    o_any    = 1'b0;
    o_winner = '0;
    w_cand   = '0;
    // Offset 1 is the highest priority, offset NREQ is the previous owner itself.
    for (int i = 1; i <= NREQ; i++) begin
      w_cand = IW'((int'(i_last) + i) % NREQ);
      if (!o_any && i_req[w_cand]) begin
        o_any    = 1'b1;
        o_winner = w_cand;
      end
    end
  end

endmodule

// File: rtl/count_arbiter.sv
// Round-robin sequencer granting one shared up-counter to NREQ requesters.
//
// state   | meaning
// IDLE    | no owner; arbitrate pending requests
// RUN     | counter owned by r_winner, counting up to r_tgt
// DONE    | run reached its length; done pulse, grant still held
module count_arbiter
  import count_arbiter_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  output logic [NREQ-1:0]       grant,
  output logic [WIDTH-1:0]      count,
  output logic                  done,
  output logic                  aborted,
  output logic                  busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t        r_state;
  logic [NREQ-1:0]   r_grant;
  logic [WIDTH-1:0]  r_count;
  logic [WIDTH-1:0]  r_tgt;
  logic [IW-1:0]     r_last;
  logic [IW-1:0]     r_winner;
  logic              r_done;
  logic              r_aborted;

  logic [IW-1:0]     w_pick;
  logic              w_any;
  logic [WIDTH-1:0]  w_len;
  logic [WIDTH-1:0]  w_count_inc;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .i_req    (req),
    .i_last   (r_last),
    .o_winner (w_pick),
    .o_any    (w_any)
  );

  assign w_len       = len[int'(w_pick)*WIDTH +: WIDTH];
  assign w_count_inc = r_count + WIDTH'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_count   <= '0;
      r_tgt     <= '0;
      r_last    <= IW'(NREQ-1);
      r_winner  <= '0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_winner <= w_pick;
            r_tgt    <= w_len;
            r_grant  <= NREQ'(onehot(int'(w_pick)));
            r_count  <= '0;
            if (w_len == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // A dropped request cancels the run; the counter freezes where it was.
          if (!req[r_winner]) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_aborted <= 1'b1;
            r_last    <= r_winner;
          end else begin
            r_count <= w_count_inc;
            if (w_count_inc == r_tgt) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_last  <= r_winner;
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign grant   = r_grant;
  assign count   = r_count;
  assign done    = r_done;
  assign aborted = r_aborted;
  assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_count_arbiter.sv
// Directed bench for count_arbiter with NREQ=4, WIDTH=8.
module tb_count_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] len;
  logic [3:0]  grant;
  logic [7:0]  count;
  logic        done;
  logic        aborted;
  logic        busy;

  int total = 0;
  int bad   = 0;

  count_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .len     (len),
    .grant   (grant),
    .count   (count),
    .done    (done),
    .aborted (aborted),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and land 1ns after it for sampling and driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b0000;
    len   = 32'h0;
    #2;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    total++; if (count !== 8'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", count); end
    total++; if ({done, aborted, busy} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b expected 000", {done, aborted, busy}); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_single();
    len[7:0] = 8'd3;
    req      = 4'b0001;
    step();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL single_grant: got %b expected 0001", grant); end
    total++; if (count !== 8'd0) begin bad++; $display("FAIL single_count0: got %0d expected 0", count); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b expected 1", busy); end
    for (int k = 1; k <= 3; k++) begin
      step();
      total++; if (count !== 8'(k)) begin bad++; $display("FAIL single_count: got %0d expected %0d", count, k); end
      total++; if (done !== (k == 3)) begin bad++; $display("FAIL single_done: k=%0d got %b expected %b", k, done, (k == 3)); end
      total++; if (grant !== 4'b0001) begin bad++; $display("FAIL single_grant_hold: got %b expected 0001", grant); end
    end
    req = 4'b0000;
    step();
    total++; if ({grant, done, busy} !== 6'b000000) begin bad++; $display("FAIL single_end: got grant=%b done=%b busy=%b expected all 0", grant, done, busy); end
    total++; if (count !== 8'd3) begin bad++; $display("FAIL single_count_hold: got %0d expected 3", count); end
  endtask

  task automatic test_contention();
    do_reset();
    len = {8'd1, 8'd1, 8'd1, 8'd1};
    req = 4'b1111;
    for (int n = 0; n < 15; n++) begin
      logic [3:0] exp_g;
      logic       exp_d;
      logic [7:0] exp_c;
      step();
      exp_g = ((n % 3) < 2) ? 4'(1 << ((n / 3) % 4)) : 4'b0000;
      exp_d = ((n % 3) == 1);
      exp_c = ((n % 3) == 0) ? 8'd0 : 8'd1;
      total++; if (grant !== exp_g) begin bad++; $display("FAIL rr_grant: n=%0d got %b expected %b", n, grant, exp_g); end
      total++; if (done !== exp_d) begin bad++; $display("FAIL rr_done: n=%0d got %b expected %b", n, done, exp_d); end
      total++; if (count !== exp_c) begin bad++; $display("FAIL rr_count: n=%0d got %0d expected %0d", n, count, exp_c); end
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_zero_len();
    len[23:16] = 8'd0;
    req        = 4'b0100;
    step();
    total++; if (grant !== 4'b0100) begin bad++; $display("FAIL zero_grant: got %b expected 0100", grant); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done: got %b expected 1", done); end
    total++; if (count !== 8'd0) begin bad++; $display("FAIL zero_count: got %0d expected 0", count); end
    req = 4'b0000;
    step();
    total++; if ({grant, done, busy} !== 6'b000000) begin bad++; $display("FAIL zero_end: got grant=%b done=%b busy=%b expected all 0", grant, done, busy); end
    total++; if (count !== 8'd0) begin bad++; $display("FAIL zero_count_hold: got %0d expected 0", count); end
  endtask

  task automatic test_abort();
    len[15:8] = 8'd10;
    req       = 4'b0010;
    step();
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL abort_grant: got %b expected 0010", grant); end
    len[15:8] = 8'd2;  // must be ignored: target was captured at grant
    for (int k = 1; k <= 4; k++) begin
      step();
      total++; if (count !== 8'(k) || done !== 1'b0) begin bad++; $display("FAIL abort_run: got count=%0d done=%b expected count=%0d done=0", count, done, k); end
    end
    req = 4'b0000;
    step();
    total++; if (aborted !== 1'b1) begin bad++; $display("FAIL abort_pulse: got %b expected 1", aborted); end
    total++; if (count !== 8'd4) begin bad++; $display("FAIL abort_count: got %0d expected 4", count); end
    total++; if ({grant, done, busy} !== 6'b000000) begin bad++; $display("FAIL abort_state: got grant=%b done=%b busy=%b expected all 0", grant, done, busy); end
    step();
    total++; if (aborted !== 1'b0) begin bad++; $display("FAIL abort_one_cycle: got %b expected 0", aborted); end
    total++; if (count !== 8'd4) begin bad++; $display("FAIL abort_count_hold: got %0d expected 4", count); end
  endtask

  task automatic test_reset_midrun();
    len[7:0] = 8'd10;
    req      = 4'b0001;
    for (int k = 0; k <= 5; k++) step();
    total++; if (count !== 8'd5) begin bad++; $display("FAIL midrun_pre: got %0d expected 5", count); end
    #2;
    reset = 1'b1;
    #1;
    total++; if ({grant, count, done, aborted, busy} !== 15'd0) begin bad++; $display("FAIL midrun_async: got grant=%b count=%0d done=%b aborted=%b busy=%b expected all 0", grant, count, done, aborted, busy); end
    req = 4'b1001;
    step();
    total++; if ({grant, done, aborted} !== 6'd0) begin bad++; $display("FAIL midrun_held: got grant=%b done=%b aborted=%b expected all 0", grant, done, aborted); end
    reset = 1'b0;
    step();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL midrun_first: got %b expected 0001", grant); end
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_full_range();
    do_reset();
    len[7:0] = 8'd255;
    req      = 4'b0001;
    step();
    total++; if (grant !== 4'b0001 || count !== 8'd0) begin bad++; $display("FAIL full_grant: got grant=%b count=%0d expected 0001/0", grant, count); end
    for (int k = 1; k <= 255; k++) begin
      step();
      total++; if (count !== 8'(k) || done !== (k == 255)) begin bad++; $display("FAIL full_count: k=%0d got count=%0d done=%b", k, count, done); end
    end
    req = 4'b0000;
    step();
    total++; if (count !== 8'd255 || grant !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL full_end: got count=%0d grant=%b busy=%b expected 255/0000/0", count, grant, busy); end
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    len   = 32'h0;
    test_reset();
    test_single();
    test_contention();
    test_zero_len();
    test_abort();
    test_reset_midrun();
    test_full_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
